dp_result_acc: RTL and testbench

Downstream consumer of the arithmetic datapath. Takes one signed N-bit result `Y` plus carry-out `co` per cycle over a valid/ready handshake and accumulates a burst of results into a wide saturating signed accumulator. When the burst closes, it presents the sum, beat count and carry count as one output record. It is the reduction stage between the ALU and the neuron-output writeback.

---
 rtl/dp_result_acc_pkg.sv | 38 +++
 rtl/dp_result_acc_if.sv | 29 ++
 rtl/dp_result_acc_sat_add.sv | 26 ++
 rtl/dp_result_acc.sv | 97 +++++++++
 tb/tb_dp_result_acc.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/dp_result_acc_pkg.sv
// Shared types and saturation helpers for the burst result accumulator.
package dp_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_e;

  localparam int unsigned WIDE_W = 64;
  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef struct packed {
    wide_t sum;
    logic  ovf;
  } sat_res_t;

  // Largest positive value of a signed acc_w-bit accumulator (acc_w <= 63).
  function automatic wide_t sat_max(int unsigned acc_w);
    return wide_t'({1'b0, {(WIDE_W-1){1'b1}}} >> (WIDE_W - acc_w));
  endfunction

  function automatic wide_t sat_min(int unsigned acc_w);
    return ~sat_max(acc_w);
  endfunction

  // Operands must already be sign-extended values that fit in acc_w bits.
  function automatic sat_res_t sat_add(wide_t a, wide_t b, int unsigned acc_w);
    sat_res_t r;
    wide_t    s;
    s     = a + b;
    r.ovf = (s > sat_max(acc_w)) || (s < sat_min(acc_w));
    r.sum = (s > sat_max(acc_w)) ? sat_max(acc_w) :
            (s < sat_min(acc_w)) ? sat_min(acc_w) : s;
    return r;
  endfunction

endpackage

// File: rtl/dp_result_acc_if.sv
// Beat input and burst-record output of the result accumulator.
interface dp_result_acc_if #(
  parameter int unsigned N         = 16,
  parameter int unsigned ACC_W     = 32,
  parameter int unsigned MAX_BEATS = 16,
  parameter int unsigned CNT_W     = $clog2(MAX_BEATS + 1)
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [N-1:0]     in_y;
  logic                    in_co;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_acc;
  logic [CNT_W-1:0]        out_count;
  logic [CNT_W-1:0]        out_carries;
  logic                    out_sat;

  modport master (
    output in_valid, in_y, in_co, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_count, out_carries, out_sat
  );

  modport slave (
    input  in_valid, in_y, in_co, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_carries, out_sat
  );
endinterface

// File: rtl/dp_result_acc_sat_add.sv
// Combinational signed saturating add of a sign-extended N-bit beat into the accumulator.
module dp_sat_add
  import dp_acc_pkg::*;
#(
  parameter int unsigned N     = 16,
  parameter int unsigned ACC_W = 32
) (
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic signed [N-1:0]     y_i,
  output logic signed [ACC_W-1:0] sum_c_o,
  output logic                    ovf_c_o
);
  localparam logic signed [ACC_W:0] HI = (ACC_W+1)'(sat_max(ACC_W));
  localparam logic signed [ACC_W:0] LO = (ACC_W+1)'(sat_min(ACC_W));

  logic signed [ACC_W:0] sum_w;
  logic                  pos_ovf;
  logic                  neg_ovf;

  // One guard bit is enough: both operands fit in ACC_W signed bits.
  assign sum_w   = (ACC_W+1)'(acc_i) + (ACC_W+1)'(y_i);
  assign pos_ovf = sum_w > HI;
  assign neg_ovf = sum_w < LO;
  assign ovf_c_o = pos_ovf || neg_ovf;
  assign sum_c_o = pos_ovf ? ACC_W'(HI) : neg_ovf ? ACC_W'(LO) : sum_w[ACC_W-1:0];
endmodule

// File: rtl/dp_result_acc.sv
// Burst reduction stage: sums datapath results with saturation and emits one record per burst.
module dp_result_acc
  import dp_acc_pkg::*;
#(
  parameter int unsigned N         = 16,
  parameter int unsigned ACC_W     = 32,
  parameter int unsigned MAX_BEATS = 16
) (
  input logic        clk,
  input logic        rst,
  dp_result_acc_if.slave acc_if
);
  localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);

  acc_state_e              state_q;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [CNT_W-1:0]        carries_q, carries_d;
  logic                    sat_q, sat_d;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic                    close_d;
  logic                    accept;
  logic signed [ACC_W-1:0] sum_c;
  logic                    ovf_c;

  dp_sat_add #(.N(N), .ACC_W(ACC_W)) u_sat_add (
    .acc_i   (acc_q),
    .y_i     (acc_if.in_y),
    .sum_c_o (sum_c),
    .ovf_c_o (ovf_c)
  );

  assign accept = acc_if.in_valid && in_ready_q;

  // Next burst totals for an accepted beat; count cannot exceed MAX_BEATS.
  always_comb begin
    acc_d     = sum_c;
    count_d   = count_q + CNT_W'(1);
    carries_d = carries_q + CNT_W'(acc_if.in_co);
    sat_d     = sat_q || ovf_c;
    close_d   = acc_if.in_last || (count_d == CNT_W'(MAX_BEATS));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      carries_q   <= '0;
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_q     <= acc_d;
            count_q   <= count_d;
            carries_q <= carries_d;
            sat_q     <= sat_d;
            if (close_d) begin
              state_q     <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (acc_if.out_ready) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            carries_q   <= '0;
            sat_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign acc_if.in_ready    = in_ready_q;
  assign acc_if.out_valid   = out_valid_q;
  assign acc_if.out_acc     = acc_q;
  assign acc_if.out_count   = count_q;
  assign acc_if.out_carries = carries_q;
  assign acc_if.out_sat     = sat_q;
endmodule

// File: tb/tb_dp_result_acc.sv
// Bench for dp_result_acc: 32-bit and 18-bit accumulators driven in lock-step against a burst model.
module tb_dp_result_acc;
  localparam int unsigned N  = 16;
  localparam int unsigned MB = 16;
  localparam int unsigned CW = $clog2(MB + 1);

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_co, in_last, out_ready;
  logic signed [N-1:0] in_y;

  always #5 clk = ~clk;

  dp_result_acc_if #(.N(N), .ACC_W(32), .MAX_BEATS(MB)) if32();
  dp_result_acc_if #(.N(N), .ACC_W(18), .MAX_BEATS(MB)) if18();

  assign if32.in_valid = in_valid;  assign if18.in_valid = in_valid;
  assign if32.in_y = in_y;          assign if18.in_y = in_y;
  assign if32.in_co = in_co;        assign if18.in_co = in_co;
  assign if32.in_last = in_last;    assign if18.in_last = in_last;
  assign if32.out_ready = out_ready; assign if18.out_ready = out_ready;

  dp_result_acc #(.N(N), .ACC_W(32), .MAX_BEATS(MB)) u32 (.clk(clk), .rst(rst), .acc_if(if32.slave));
  dp_result_acc #(.N(N), .ACC_W(18), .MAX_BEATS(MB)) u18 (.clk(clk), .rst(rst), .acc_if(if18.slave));

  int n_tests = 0;
  int n_fail  = 0;

  // Burst model: a record is held or beats are being collected.
  bit     m_hold;
  longint m_a32, m_a18;
  int     m_cnt, m_car;
  bit     m_s32, m_s18;

  task automatic model_clear();
    m_hold = 0; m_a32 = 0; m_a18 = 0; m_cnt = 0; m_car = 0; m_s32 = 0; m_s18 = 0;
  endtask

  task automatic sat_acc(inout longint a, inout bit s, input int w, input longint y);
    longint hi, lo;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -hi - 1;
    a = a + y;
    if (a > hi) begin a = hi; s = 1; end
    if (a < lo) begin a = lo; s = 1; end
  endtask

  // Advance model by the current inputs, then clock and settle past the edge.
  task automatic cycle();
    if (rst) model_clear();
    else if (m_hold) begin
      if (out_ready) model_clear();
    end else if (in_valid) begin
      sat_acc(m_a32, m_s32, 32, longint'(in_y));
      sat_acc(m_a18, m_s18, 18, longint'(in_y));
      m_cnt++;
      m_car += int'(in_co);
      if (in_last || m_cnt == MB) m_hold = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    in_valid = 0; in_y = '0; in_co = 0; in_last = 0; out_ready = 0;
  endtask

  task automatic beat(input int y, input bit co, input bit last);
    in_valid = 1; in_y = N'(y); in_co = co; in_last = last;
    cycle();
  endtask

  task automatic consume();
    quiet(); out_ready = 1; cycle(); out_ready = 0;
  endtask

  task automatic test_reset();
    quiet(); rst = 1; in_valid = 1; in_y = N'($urandom);
    cycle(); cycle();
    n_tests++;
    if (if32.out_valid !== 1'b0 || if32.in_ready !== 1'b1 || if18.out_valid !== 1'b0 || if18.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_hs: valid=%b/%b ready=%b/%b want 0/0 1/1", if32.out_valid, if18.out_valid, if32.in_ready, if18.in_ready);
    end
    n_tests++;
    if (if32.out_acc !== 32'sd0 || if18.out_acc !== 18'sd0 || if32.out_count !== '0 || if32.out_carries !== '0 || if32.out_sat !== 1'b0 || if18.out_sat !== 1'b0) begin
      n_fail++; $display("FAIL reset_rec: acc=%0d/%0d cnt=%0d car=%0d sat=%b/%b want all 0", if32.out_acc, if18.out_acc, if32.out_count, if32.out_carries, if32.out_sat, if18.out_sat);
    end
    rst = 0; quiet();
  endtask

  task automatic test_basic();
    beat(100, 1, 0);
    n_tests++;
    if (if32.in_ready !== 1'b1 || if32.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_mid: ready=%b valid=%b want 1 0", if32.in_ready, if32.out_valid);
    end
    beat(-30, 0, 0);
    beat(5, 1, 1);
    n_tests++;
    if (if32.out_valid !== 1'b1 || if32.in_ready !== 1'b0 || if32.out_acc !== 32'sd75 || if32.out_count !== CW'(3) || if32.out_carries !== CW'(2)) begin
      n_fail++; $display("FAIL basic_rec: valid=%b ready=%b acc=%0d cnt=%0d car=%0d want 1 0 75 3 2", if32.out_valid, if32.in_ready, if32.out_acc, if32.out_count, if32.out_carries);
    end
    consume();
    n_tests++;
    if (if32.in_ready !== 1'b1 || if32.out_valid !== 1'b0 || if32.out_acc !== 32'sd0) begin
      n_fail++; $display("FAIL basic_drain: ready=%b valid=%b acc=%0d want 1 0 0", if32.in_ready, if32.out_valid, if32.out_acc);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) beat(32767, 0, i == 4);
    n_tests++;
    if (if18.out_acc !== 18'sd131071 || if18.out_sat !== 1'b1 || if32.out_acc !== 32'sd163835 || if32.out_sat !== 1'b0) begin
      n_fail++; $display("FAIL sat_pos: acc18=%0d sat18=%b acc32=%0d sat32=%b want 131071 1 163835 0", if18.out_acc, if18.out_sat, if32.out_acc, if32.out_sat);
    end
    consume();
    for (int i = 0; i < 5; i++) beat(-32768, 0, i == 4);
    n_tests++;
    if (if18.out_acc !== -18'sd131072 || if18.out_sat !== 1'b1 || if32.out_acc !== -32'sd163840 || if32.out_sat !== 1'b0) begin
      n_fail++; $display("FAIL sat_neg: acc18=%0d sat18=%b acc32=%0d sat32=%b want -131072 1 -163840 0", if18.out_acc, if18.out_sat, if32.out_acc, if32.out_sat);
    end
    consume();
    n_tests++;
    if (if18.out_sat !== 1'b0) begin
      n_fail++; $display("FAIL sat_clear: sat18=%b want 0", if18.out_sat);
    end
  endtask

  task automatic test_autoclose();
    for (int i = 0; i < MB; i++) beat(1, 0, 0);
    n_tests++;
    if (if32.out_valid !== 1'b1 || if32.out_acc !== 32'sd16 || if32.out_count !== CW'(16)) begin
      n_fail++; $display("FAIL auto_rec: valid=%b acc=%0d cnt=%0d want 1 16 16", if32.out_valid, if32.out_acc, if32.out_count);
    end
    beat(1, 0, 0);
    beat(1, 0, 0);
    n_tests++;
    if (if32.in_ready !== 1'b0 || if32.out_count !== CW'(16) || if32.out_acc !== 32'sd16) begin
      n_fail++; $display("FAIL auto_17th: ready=%b cnt=%0d acc=%0d want 0 16 16", if32.in_ready, if32.out_count, if32.out_acc);
    end
    out_ready = 1; beat(9, 0, 1); out_ready = 0;
    n_tests++;
    if (if32.in_ready !== 1'b1 || if32.out_valid !== 1'b0 || if32.out_count !== '0) begin
      n_fail++; $display("FAIL auto_drain: ready=%b valid=%b cnt=%0d want 1 0 0", if32.in_ready, if32.out_valid, if32.out_count);
    end
    beat(9, 0, 1);
    n_tests++;
    if (if32.out_valid !== 1'b1 || if32.out_acc !== 32'sd9 || if32.out_count !== CW'(1)) begin
      n_fail++; $display("FAIL auto_next: valid=%b acc=%0d cnt=%0d want 1 9 1", if32.out_valid, if32.out_acc, if32.out_count);
    end
    consume();
  endtask

  task automatic test_backpressure();
    int     r;
    longint exp_acc;
    exp_acc = 0;
    for (int i = 0; i < 3; i++) begin
      r = int'($urandom_range(0, 2000)) - 1000;
      exp_acc += r;
      beat(r, 1, i == 2);
    end
    for (int c = 0; c < 5; c++) begin
      out_ready = 0;
      beat(int'($urandom_range(0, 65535)) - 32768, $urandom_range(0, 1) == 1, c[0]);
      n_tests++;
      if (if32.in_ready !== 1'b0 || if32.out_valid !== 1'b1 || if32.out_acc !== 32'(exp_acc) || if32.out_count !== CW'(3) || if32.out_carries !== CW'(3)) begin
        n_fail++; $display("FAIL bp_hold[%0d]: ready=%b valid=%b acc=%0d cnt=%0d car=%0d want 0 1 %0d 3 3", c, if32.in_ready, if32.out_valid, if32.out_acc, if32.out_count, if32.out_carries, exp_acc);
      end
    end
    consume();
    r = int'($urandom_range(0, 500));
    beat(r, 0, 1);
    n_tests++;
    if (if32.out_valid !== 1'b1 || if32.out_acc !== 32'(r) || if32.out_count !== CW'(1) || if32.out_carries !== '0) begin
      n_fail++; $display("FAIL bp_fresh: valid=%b acc=%0d cnt=%0d car=%0d want 1 %0d 1 0", if32.out_valid, if32.out_acc, if32.out_count, if32.out_carries, r);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    beat(7, 0, 0);
    beat(8, 1, 0);
    quiet(); rst = 1; cycle(); rst = 0;
    n_tests++;
    if (if32.out_valid !== 1'b0 || if32.out_count !== '0 || if32.out_acc !== 32'sd0) begin
      n_fail++; $display("FAIL rstmid_clear: valid=%b cnt=%0d acc=%0d want 0 0 0", if32.out_valid, if32.out_count, if32.out_acc);
    end
    beat(3, 0, 1);
    n_tests++;
    if (if32.out_valid !== 1'b1 || if32.out_acc !== 32'sd3 || if32.out_count !== CW'(1) || if32.out_carries !== '0) begin
      n_fail++; $display("FAIL rstmid_rec: valid=%b acc=%0d cnt=%0d car=%0d want 1 3 1 0", if32.out_valid, if32.out_acc, if32.out_count, if32.out_carries);
    end
    consume();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      in_y      = N'($urandom);
      in_co     = $urandom_range(0, 1) == 1;
      in_last   = $urandom_range(0, 7) == 0;
      out_ready = $urandom_range(0, 2) != 0;
      rst       = $urandom_range(0, 149) == 0;
      cycle();
      n_tests++;
      if (if32.in_ready !== !m_hold || if32.out_valid !== m_hold || if18.in_ready !== !m_hold || if18.out_valid !== m_hold) begin
        n_fail++; $display("FAIL rnd_hs[%0d]: ready=%b/%b valid=%b/%b want hold=%b", c, if32.in_ready, if18.in_ready, if32.out_valid, if18.out_valid, m_hold);
      end
      if (m_hold) begin
        n_tests++;
        if (if32.out_acc !== 32'(m_a32) || if18.out_acc !== 18'(m_a18) || if32.out_count !== CW'(m_cnt) || if18.out_count !== CW'(m_cnt) ||
            if32.out_carries !== CW'(m_car) || if32.out_sat !== m_s32 || if18.out_sat !== m_s18) begin
          n_fail++; $display("FAIL rnd_rec[%0d]: acc=%0d/%0d cnt=%0d car=%0d sat=%b/%b want %0d/%0d %0d %0d %b/%b", c, if32.out_acc, if18.out_acc, if32.out_count,
                             if32.out_carries, if32.out_sat, if18.out_sat, m_a32, m_a18, m_cnt, m_car, m_s32, m_s18);
        end
      end
    end
    rst = 0; quiet(); out_ready = 1; cycle(); out_ready = 0;
  endtask

  initial begin
    quiet(); rst = 1; model_clear();
    @(negedge clk);
    test_reset();
    test_basic();
    test_saturation();
    test_autoclose();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
